// File: rtl/note_lane_dropper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : note_lane_dropper
// Description : Single-lane falling-note game element. A start key arms a
//               spawn delay. The note then falls one step per frame and is
//               judged on a hit-key press edge (PERFECT / GOOD) or becomes a
//               MISS when it reaches the judgement floor. A restart key
//               returns the lane to idle.
// Ports       : frame_clk      - frame-rate clock
//               Reset          - synchronous active-high reset
//               keycode        - first pressed key code
//               keycode_second - second pressed key code
//               dropX          - note X (constant X_START)
//               dropY          - note top Y
//               visible        - note sprite enable (FALL only)
//               hit            - one-frame pulse on a judged hit
//               grade          - 00 none, 01 miss, 10 good, 11 perfect
//               done           - lane resolved
// Revision    : 1.0 - initial release
// ============================================================================
module note_lane_dropper #(
  parameter int unsigned X_START     = 380,
  parameter int unsigned Y_START     = 100,
  parameter int unsigned Y_MAX       = 400,
  parameter int unsigned SIZE        = 40,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned DELAY       = 1760,
  parameter logic [7:0]  HIT_KEY     = 8'h50,
  parameter logic [7:0]  START_KEY   = 8'h2c,
  parameter logic [7:0]  RESTART_KEY = 8'h01,
  parameter int unsigned GOOD_LO     = 340,
  parameter int unsigned PERF_LO     = 360,
  parameter int unsigned PERF_HI     = 380
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_second,
  output logic [9:0] dropX,
  output logic [9:0] dropY,
  output logic       visible,
  output logic       hit,
  output logic [1:0] grade,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FALL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  C_GRADE_NONE = 2'b00;
  localparam logic [1:0]  C_GRADE_MISS = 2'b01;
  localparam logic [1:0]  C_GRADE_GOOD = 2'b10;
  localparam logic [1:0]  C_GRADE_PERF = 2'b11;

  localparam logic [9:0]  C_X_START    = 10'(X_START);
  localparam logic [9:0]  C_Y_START    = 10'(Y_START);
  localparam logic [9:0]  C_Y_CLAMP    = 10'(Y_MAX - SIZE);
  localparam logic [9:0]  C_SPEED_Y    = 10'(SPEED);
  localparam logic [10:0] C_SIZE       = 11'(SIZE);
  localparam logic [10:0] C_GOOD_LO    = 11'(GOOD_LO);
  localparam logic [10:0] C_PERF_LO    = 11'(PERF_LO);
  localparam logic [10:0] C_PERF_HI    = 11'(PERF_HI);
  localparam logic [10:0] C_Y_MAX_B    = 11'(Y_MAX);
  localparam logic [11:0] C_Y_MAX_N    = 12'(Y_MAX);
  localparam logic [11:0] C_SPEED_N    = 12'(SPEED);
  // Only compared while waiting, which is never entered when DELAY is 0,
  // so the wrapped value for that case is harmless.
  localparam logic [11:0] C_DELAY_LAST = 12'(DELAY - 1);
  localparam logic        C_NO_WAIT    = (DELAY == 0);

  state_t      r_state, w_state_d;
  logic [11:0] r_count, w_count_d;
  logic [9:0]  r_drop_y, w_drop_y_d;
  logic        r_hit, w_hit_d;
  logic [1:0]  r_grade, w_grade_d;
  logic        r_key_hist;

  logic        w_start_now;
  logic        w_hit_now;
  logic        w_restart_now;
  logic        w_press;
  logic [10:0] w_bottom;
  logic [11:0] w_bottom_next;
  logic        w_in_perf;
  logic        w_in_good;

  assign w_start_now   = (keycode == START_KEY)   || (keycode_second == START_KEY);
  assign w_hit_now     = (keycode == HIT_KEY)     || (keycode_second == HIT_KEY);
  assign w_restart_now = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);

  // Judging reacts only to the rising edge of the hit key, so holding it
  // down never produces a second judgement.
  assign w_press = w_hit_now && !r_key_hist;

  // One extra bit on each sum keeps the floor comparison from wrapping.
  assign w_bottom      = {1'b0, r_drop_y} + C_SIZE;
  assign w_bottom_next = {1'b0, w_bottom} + C_SPEED_N;

  assign w_in_perf = (w_bottom >= C_PERF_LO) && (w_bottom < C_PERF_HI);
  assign w_in_good = (w_bottom >= C_GOOD_LO) && (w_bottom < C_Y_MAX_B);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_drop_y   <= C_Y_START;
      r_hit      <= 1'b0;
      r_grade    <= C_GRADE_NONE;
      r_key_hist <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_drop_y   <= w_drop_y_d;
      r_hit      <= w_hit_d;
      r_grade    <= w_grade_d;
      r_key_hist <= w_hit_now;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_drop_y_d = r_drop_y;
    w_grade_d  = r_grade;
    w_hit_d    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_now) begin
          w_count_d  = '0;
          w_drop_y_d = C_Y_START;
          w_state_d  = C_NO_WAIT ? ST_FALL : ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_count_d = r_count + 12'd1;
        if (r_count == C_DELAY_LAST) begin
          w_state_d = ST_FALL;
        end
      end

      ST_FALL: begin
        // A qualifying press wins over reaching the floor on the same frame.
        if (w_press && w_in_perf) begin
          w_grade_d = C_GRADE_PERF;
          w_hit_d   = 1'b1;
          w_state_d = ST_DONE;
        end else if (w_press && w_in_good) begin
          w_grade_d = C_GRADE_GOOD;
          w_hit_d   = 1'b1;
          w_state_d = ST_DONE;
        end else if (w_bottom_next >= C_Y_MAX_N) begin
          w_drop_y_d = C_Y_CLAMP;
          w_grade_d  = C_GRADE_MISS;
          w_state_d  = ST_DONE;
        end else begin
          w_drop_y_d = r_drop_y + C_SPEED_Y;
        end
      end

      ST_DONE: begin
        if (w_restart_now) begin
          w_grade_d  = C_GRADE_NONE;
          w_drop_y_d = C_Y_START;
          w_state_d  = ST_IDLE;
        end
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  assign dropX   = C_X_START;
  assign dropY   = r_drop_y;
  assign visible = (r_state == ST_FALL);
  assign hit     = r_hit;
  assign grade   = r_grade;
  assign done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_note_lane_dropper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_note_lane_dropper
// Description : Self-checking bench for note_lane_dropper: a table of
//               hand-derived vectors, directed multi-frame scenarios, window
//               boundary sweeps and random key traffic, all checked against
//               a frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_lane_dropper;

  localparam int DELAY_T = 4;
  localparam int X_START = 380;
  localparam int Y_START = 100;
  localparam int Y_MAX   = 400;
  localparam int SIZE    = 40;
  localparam int SPEED   = 1;
  localparam int GOOD_LO = 340;
  localparam int PERF_LO = 360;
  localparam int PERF_HI = 380;
  localparam logic [7:0] K_HIT   = 8'h50;
  localparam logic [7:0] K_START = 8'h2c;
  localparam logic [7:0] K_RST   = 8'h01;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_FALL = 2;
  localparam int P_DONE = 3;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [7:0] keycode_second = 8'h00;
  logic [9:0] dropX, dropY;
  logic       visible, hit, done;
  logic [1:0] grade;

  always #5 frame_clk = ~frame_clk;

  note_lane_dropper #(.DELAY(DELAY_T)) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .dropX          (dropX),
    .dropY          (dropY),
    .visible        (visible),
    .hit            (hit),
    .grade          (grade),
    .done           (done)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level model of the lane.
  int m_phase  = P_IDLE;
  int m_waited = 0;
  int m_y      = Y_START;
  int m_grade  = 0;
  int m_hit    = 0;
  int m_prev   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] k1, input logic [7:0] k2);
    int sk, hk, rk, press, bottom;
    if (r) begin
      m_phase = P_IDLE; m_waited = 0; m_y = Y_START;
      m_grade = 0; m_hit = 0; m_prev = 0;
      return;
    end
    sk = int'((k1 == K_START) || (k2 == K_START));
    hk = int'((k1 == K_HIT)   || (k2 == K_HIT));
    rk = int'((k1 == K_RST)   || (k2 == K_RST));
    press = int'(hk == 1 && m_prev == 0);
    m_hit = 0;
    case (m_phase)
      P_IDLE: if (sk == 1) begin
        m_waited = 0;
        m_phase = (DELAY_T == 0) ? P_FALL : P_WAIT;
      end
      P_WAIT: begin
        m_waited++;
        if (m_waited == DELAY_T) m_phase = P_FALL;
      end
      P_FALL: begin
        bottom = m_y + SIZE;
        if (press == 1 && bottom >= PERF_LO && bottom < PERF_HI) begin
          m_grade = 3; m_hit = 1; m_phase = P_DONE;
        end else if (press == 1 && bottom >= GOOD_LO && bottom < Y_MAX) begin
          m_grade = 2; m_hit = 1; m_phase = P_DONE;
        end else if (bottom + SPEED >= Y_MAX) begin
          m_y = Y_MAX - SIZE; m_grade = 1; m_phase = P_DONE;
        end else begin
          m_y = m_y + SPEED;
        end
      end
      P_DONE: if (rk == 1) begin
        m_phase = P_IDLE; m_grade = 0; m_y = Y_START;
      end
      default: m_phase = P_IDLE;
    endcase
    m_prev = hk;
  endtask

  function automatic int pack(input int y, input int vis, input int h, input int g, input int d);
    return (X_START << 15) | (y << 5) | (vis << 4) | (h << 3) | (g << 1) | d;
  endfunction

  function automatic int dut_pack();
    return int'({7'd0, dropX, dropY, visible, hit, grade, done});
  endfunction

  function automatic int model_pack();
    return pack(m_y, int'(m_phase == P_FALL), m_hit, m_grade, int'(m_phase == P_DONE));
  endfunction

  // One frame: drive inputs, let the edge happen, compare against the model.
  task automatic tick(input logic r, input logic [7:0] k1, input logic [7:0] k2);
    Reset = r; keycode = k1; keycode_second = k2;
    @(posedge frame_clk);
    model_edge(r, k1, k2);
    #1;
    check("frame", dut_pack(), model_pack());
  endtask

  task automatic run_until_y(input int target);
    for (int n = 0; n < 600; n++) begin
      if (m_phase == P_FALL && m_y == target) return;
      tick(1'b0, 8'h00, 8'h00);
    end
    check("run_until_y_timeout", m_y, target);
    errors++;
    $display("FAIL run_until_y: bound expired waiting for dropY=%0d", target);
  endtask

  task automatic run_until_done(input logic [7:0] k2, output int hit_seen);
    hit_seen = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_phase == P_DONE) return;
      tick(1'b0, 8'h00, k2);
      if (hit === 1'b1) hit_seen = 1;
    end
    errors++;
    checks++;
    $display("FAIL run_until_done: bound expired, actual phase %0d required %0d", m_phase, P_DONE);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] k1;
    logic [7:0] k2;
    int         y;
    int         vis;
    int         h;
    int         g;
    int         d;
  } vec_t;

  vec_t vecs[12];
  int   by[7] = '{299, 300, 319, 320, 339, 340, 359};
  int   bg[7] = '{0,   2,   2,   3,   3,   2,   2};

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 8'h00;
      4:          return K_START;
      5, 6:       return K_HIT;
      7:          return K_RST;
      default:    return 8'($urandom);
    endcase
  endfunction

  initial begin
    int hs;

    // Reset, hit key ignored in idle, start, DELAY=4 wait frames, first fall
    // frames, an early press that is ignored, then reset mid-fall.
    vecs[0]  = '{1'b1, 8'h00,   8'h00, 100, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, K_HIT,   8'h00, 100, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, K_START, 8'h00, 100, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 8'h00,   8'h00, 100, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 8'h00,   8'h00, 100, 0, 0, 0, 0};
    vecs[5]  = '{1'b0, 8'h00,   8'h00, 100, 0, 0, 0, 0};
    vecs[6]  = '{1'b0, 8'h00,   8'h00, 100, 1, 0, 0, 0};
    vecs[7]  = '{1'b0, 8'h00,   8'h00, 101, 1, 0, 0, 0};
    vecs[8]  = '{1'b0, K_HIT,   8'h00, 102, 1, 0, 0, 0};
    vecs[9]  = '{1'b0, K_HIT,   8'h00, 103, 1, 0, 0, 0};
    vecs[10] = '{1'b1, 8'h00,   8'h00, 100, 0, 0, 0, 0};
    vecs[11] = '{1'b0, 8'h00,   8'h00, 100, 0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].rst, vecs[i].k1, vecs[i].k2);
      check($sformatf("vec%0d", i), dut_pack(),
            pack(vecs[i].y, vecs[i].vis, vecs[i].h, vecs[i].g, vecs[i].d));
    end

    // Reset during FALL at dropY=250.
    tick(1'b0, K_START, 8'h00);
    run_until_y(250);
    check("fall_y250", int'(dropY), 250);
    tick(1'b1, 8'h00, 8'h00);
    check("rst_fall", dut_pack(), pack(100, 0, 0, 0, 0));
    tick(1'b0, 8'h00, 8'h00);
    check("rst_fall_idle", dut_pack(), pack(100, 0, 0, 0, 0));

    // Full untouched fall to a miss with exact per-frame positions.
    hs = 0;
    tick(1'b0, K_START, 8'h00);
    check("wait_vis0", int'(visible), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 8'h00);
      check("wait_vis", int'(visible), 0);
    end
    for (int y = 100; y <= 359; y++) begin
      tick(1'b0, 8'h00, 8'h00);
      if (hit === 1'b1) hs = 1;
      check("fall_step", int'({visible, dropY}), (1 << 10) | y);
    end
    tick(1'b0, 8'h00, 8'h00);
    check("miss_frame", dut_pack(), pack(360, 0, 0, 1, 1));
    check("miss_no_hit", hs, 0);

    // In DONE: start key ignored, restart key returns to idle.
    tick(1'b0, K_START, 8'h00);
    check("done_start_ignored", dut_pack(), pack(360, 0, 0, 1, 1));
    tick(1'b0, K_RST, 8'h00);
    check("restart", dut_pack(), pack(100, 0, 0, 0, 0));

    // PERFECT via keycode_second at dropY=330.
    tick(1'b0, K_START, 8'h00);
    run_until_y(330);
    tick(1'b0, 8'h00, K_HIT);
    check("perfect", dut_pack(), pack(330, 0, 1, 3, 1));
    tick(1'b0, 8'h00, K_HIT);
    check("perfect_hit_once", dut_pack(), pack(330, 0, 0, 3, 1));
    tick(1'b0, K_RST, 8'h00);

    // Early press ignored, release, then GOOD at dropY=305.
    tick(1'b0, K_START, 8'h00);
    run_until_y(200);
    tick(1'b0, K_HIT, 8'h00);
    check("early_ignored", int'({visible, dropY}), (1 << 10) | 201);
    tick(1'b0, 8'h00, 8'h00);
    run_until_y(305);
    tick(1'b0, K_HIT, 8'h00);
    check("good", dut_pack(), pack(305, 0, 1, 2, 1));
    tick(1'b0, K_RST, 8'h00);

    // Hit key held from idle through the fall: no edge, so a miss.
    tick(1'b0, K_START, K_HIT);
    run_until_done(K_HIT, hs);
    check("held_miss", dut_pack(), pack(360, 0, 0, 1, 1));
    check("held_no_hit", hs, 0);
    tick(1'b0, K_RST, 8'h00);

    // Window boundaries; the 320 case also resets during the hit frame.
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, K_START, 8'h00);
      run_until_y(by[i]);
      tick(1'b0, K_HIT, 8'h00);
      if (bg[i] == 0) begin
        check($sformatf("bnd%0d_ignored", by[i]), int'({visible, dropY}), (1 << 10) | (by[i] + 1));
        run_until_done(8'h00, hs);
        check($sformatf("bnd%0d_miss", by[i]), int'(grade), 1);
      end else begin
        check($sformatf("bnd%0d_grade", by[i]), dut_pack(), pack(by[i], 0, 1, bg[i], 1));
      end
      if (by[i] == 320) begin
        tick(1'b1, 8'h00, 8'h00);
        check("rst_hit_frame", dut_pack(), pack(100, 0, 0, 0, 0));
      end else begin
        tick(1'b0, K_RST, 8'h00);
        check($sformatf("bnd%0d_restart", by[i]), dut_pack(), pack(100, 0, 0, 0, 0));
      end
    end

    // Random key traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) == 0), pick_key(), pick_key());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_lane_dropper.md
NOTE_LANE_DROPPER -- requirements
Module: note_lane_dropper

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
  X_START, 380, fixed lane X position.
  Y_START, 100, note top Y at spawn.
  Y_MAX, 400, judgement floor Y.
  SIZE, 40, note height in pixels.
  SPEED, 1, pixels advanced per frame (1..15).
  DELAY, 1760, frames from start to spawn (0..4095).
  HIT_KEY, 8'h50, lane key code.
  START_KEY, 8'h2c, game start key code.
  RESTART_KEY, 8'h01, return-to-idle key code.
  GOOD_LO, 340, lowest note-bottom Y for a GOOD hit.
  PERF_LO, 360, lowest note-bottom Y for a PERFECT hit.
  PERF_HI, 380, note-bottom Y limit for PERFECT (exclusive).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL expose ports, one per line: name, direction, width, meaning.
  frame_clk  in  1  frame-rate clock.
  Reset  in  1  synchronous active-high reset.
  keycode  in  8  first pressed key code.
  keycode_second  in  8  second pressed key code.
  dropX  out  10  note X (always X_START).
  dropY  out  10  note top Y.
  visible  out  1  note sprite enable.
  hit  out  1  one-frame pulse on a judged hit.
  grade  out  2  00 none, 01 miss, 10 good, 11 perfect.
  done  out  1  lane resolved.

Function
REQ-004 SHALL implement the states IDLE, WAIT, FALL and DONE, with every register updated on the rising edge of frame_clk only.
REQ-005 SHALL define key_now as (keycode == K) OR (keycode_second == K), evaluated separately for each key code K.
REQ-006 SHALL define press as HIT_KEY key_now true this frame AND false in the previous frame, using a 1-bit history register.
REQ-007 SHALL move from IDLE to WAIT when the START_KEY key_now is true, clearing the 12-bit counter to 0; all other keys are ignored in IDLE.
REQ-008 SHALL, in WAIT, increment the counter once per frame and move to FALL on the frame the counter equals DELAY-1; with DELAY=0, IDLE SHALL go directly to FALL.
REQ-009 SHALL, in FALL, assert visible and compute bottom = dropY + SIZE at 11 bits so the sum cannot wrap.
REQ-010 SHALL, in FALL on a press with PERF_LO <= bottom < PERF_HI, set grade=11, pulse hit, hold dropY and move to DONE.
REQ-011 SHALL, in FALL on a press with GOOD_LO <= bottom < Y_MAX that is outside the PERFECT window, set grade=10, pulse hit, hold dropY and move to DONE.
REQ-012 SHALL ignore a press with bottom < GOOD_LO; the note keeps falling.
REQ-013 SHALL, in FALL with no qualifying press, set dropY = dropY + SPEED, except when bottom + SPEED >= Y_MAX.
REQ-014 SHALL, when bottom + SPEED >= Y_MAX with no qualifying press, clamp dropY to Y_MAX-SIZE, set grade=01, leave hit low and move to DONE.
REQ-015 SHALL give hit judgement priority over the miss check when both occur on the same frame.
REQ-016 SHALL, in DONE, hold grade and dropY, assert done, deassert visible, and ignore START_KEY.
REQ-017 SHALL move from DONE to IDLE when the RESTART_KEY key_now is true, clearing grade to 00, setting dropY to Y_START and deasserting done.
REQ-018 SHALL keep hit high for exactly one frame per judged hit.
REQ-019 SHALL keep visible low in IDLE and WAIT.

Reset
REQ-020 SHALL, while Reset is high at a frame_clk edge, force: state IDLE, counter 0, dropY=Y_START, hit 0, grade 00, done 0, visible 0, press history 0.
REQ-021 SHALL let Reset override every state, including mid-FALL and the hit-pulse frame.

Verification
REQ-022 Scenario: defaults; Reset asserted during FALL at dropY=250 -> next frame state IDLE, dropY=100, visible=0, grade=00.
REQ-023 Scenario: DELAY=4, keycode=2C for one frame, no hit key -> 4 WAIT frames, then FALL; dropY steps 100,101,...,359; on the next frame dropY=360, grade=01, done=1, hit never high.
REQ-024 Scenario: press edge on keycode_second=50 at dropY=330 (bottom 370) -> grade=11, hit high for 1 frame, dropY frozen at 330.
REQ-025 Scenario: press at dropY=200 (ignored, note keeps falling), release, then press at dropY=305 (bottom 345) -> grade=10, done=1.
REQ-026 Scenario: key 50 held continuously from IDLE through FALL -> no second edge occurs, result is a miss with grade=01.
REQ-027 Scenario: in DONE, keycode=2C -> no change; keycode=01 -> IDLE, grade=00, dropY=100.
